// File: rtl/grey_pkg.sv
// rtl/grey_pkg.sv - shared widths, luma weights and pixel constants for the grey threshold stream
package grey_pkg;

    localparam int PIX_W = 24;
    localparam int CH_W  = 8;
    localparam int ACC_W = 16;

    localparam int DEF_COEF_R = 77;
    localparam int DEF_COEF_G = 150;
    localparam int DEF_COEF_B = 29;

    localparam logic [PIX_W-1:0] BLACK = 24'h000000;
    localparam logic [PIX_W-1:0] WHITE = 24'hFFFFFF;

    // Weights are in 1/256 units and sum to 256, so the 16-bit sum cannot overflow.
    function automatic logic [CH_W-1:0] luma_of(input logic [PIX_W-1:0] rgb,
                                                 input int cr, input int cg, input int cb);
        logic [ACC_W-1:0] acc;
        acc = ACC_W'(cr) * ACC_W'(rgb[23:16])
            + ACC_W'(cg) * ACC_W'(rgb[15:8])
            + ACC_W'(cb) * ACC_W'(rgb[7:0]);
        return acc[ACC_W-1:CH_W];
    endfunction

endpackage

// File: rtl/grey_luma.sv
// rtl/grey_luma.sv - registered RGB888 to 8-bit luma stage with framing sideband
module grey_luma
    import grey_pkg::*;
#(
    parameter int COEF_R = DEF_COEF_R,
    parameter int COEF_G = DEF_COEF_G,
    parameter int COEF_B = DEF_COEF_B
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [PIX_W-1:0] rgb,
    input  logic             sop,
    input  logic             eop,
    output logic [CH_W-1:0]  luma,
    output logic             luma_sop,
    output logic             luma_eop
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            luma     <= '0;
            luma_sop <= 1'b0;
            luma_eop <= 1'b0;
        end else if (en) begin
            luma     <= luma_of(rgb, COEF_R, COEF_G, COEF_B);
            luma_sop <= sop;
            luma_eop <= eop;
        end
    end

endmodule

// File: rtl/grey_threshold_stream.sv
// rtl/grey_threshold_stream.sv - two-stage luma/threshold pipeline with per-frame white-pixel count
module grey_threshold_stream
    import grey_pkg::*;
#(
    parameter int              CNT_W     = 20,
    parameter logic [CH_W-1:0] THR_RESET = 8'd128,
    parameter int              COEF_R    = DEF_COEF_R,
    parameter int              COEF_G    = DEF_COEF_G,
    parameter int              COEF_B    = DEF_COEF_B
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH_W-1:0]  threshold,
    input  logic             binarize_en,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sop,
    input  logic             in_eop,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_sop,
    output logic             out_eop,
    input  logic             out_ready,
    output logic [CNT_W-1:0] frame_white_count,
    output logic             frame_done
);

    logic            v1, v2;
    logic            en2, load1, load2;
    logic [CH_W-1:0] s1_luma;
    logic            s1_sop, s1_eop;
    logic [CH_W-1:0] thr_q, thr_eff;
    logic            white;
    logic [CNT_W-1:0] cnt, cnt_base, cnt_sum;

    assign en2      = ~v2 | out_ready;
    assign in_ready = ~v1 | en2;
    assign load1    = in_valid & in_ready;
    assign load2    = v1 & en2;
    assign out_valid = v2;

    grey_luma #(
        .COEF_R (COEF_R),
        .COEF_G (COEF_G),
        .COEF_B (COEF_B)
    ) u_stage1 (
        .clk      (clk),
        .reset    (reset),
        .en       (load1),
        .rgb      (in_data),
        .sop      (in_sop),
        .eop      (in_eop),
        .luma     (s1_luma),
        .luma_sop (s1_sop),
        .luma_eop (s1_eop)
    );

    // The sop beat compares against the live threshold; the rest of the frame uses the latched copy.
    assign thr_eff  = s1_sop ? threshold : thr_q;
    assign white    = (s1_luma >= thr_eff);
    assign cnt_base = s1_sop ? '0 : cnt;
    assign cnt_sum  = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(white);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
        end else if (load1) begin
            v1 <= 1'b1;
        end else if (en2) begin
            v1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2                <= 1'b0;
            out_data          <= '0;
            out_sop           <= 1'b0;
            out_eop           <= 1'b0;
            thr_q             <= THR_RESET;
            cnt               <= '0;
            frame_white_count <= '0;
            frame_done        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (en2) begin
                v2 <= v1;
            end
            if (load2) begin
                out_data <= binarize_en ? (white ? WHITE : BLACK) : {s1_luma, s1_luma, s1_luma};
                out_sop  <= s1_sop;
                out_eop  <= s1_eop;
                if (s1_sop) begin
                    thr_q <= threshold;
                end
                if (s1_eop) begin
                    frame_white_count <= cnt_sum;
                    cnt               <= '0;
                    frame_done        <= 1'b1;
                end else begin
                    cnt <= cnt_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_grey_threshold_stream.sv
// tb/tb_grey_threshold_stream.sv - directed and randomised-backpressure bench for grey_threshold_stream
module tb_grey_threshold_stream;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  threshold;
    logic        binarize_en;
    logic [23:0] in_data;
    logic        in_valid, in_sop, in_eop;
    logic        in_ready;
    logic [23:0] out_data;
    logic        out_valid, out_sop, out_eop;
    logic        out_ready;
    logic [19:0] frame_white_count;
    logic        frame_done;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [23:0] out_q[$];
    logic        osop_q[$];
    logic        oeop_q[$];
    int          out_cyc_q[$];
    int          in_cyc_q[$];
    logic [19:0] done_q[$];

    grey_threshold_stream dut (
        .clk               (clk),
        .reset             (reset),
        .threshold         (threshold),
        .binarize_en       (binarize_en),
        .in_data           (in_data),
        .in_valid          (in_valid),
        .in_sop            (in_sop),
        .in_eop            (in_eop),
        .in_ready          (in_ready),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_sop           (out_sop),
        .out_eop           (out_eop),
        .out_ready         (out_ready),
        .frame_white_count (frame_white_count),
        .frame_done        (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                osop_q.push_back(out_sop);
                oeop_q.push_back(out_eop);
                out_cyc_q.push_back(cyc);
            end
            if (frame_done) done_q.push_back(frame_white_count);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1, "watchdog");
    end

    function automatic int ref_luma(input logic [23:0] p);
        return (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
    endfunction

    task automatic clear_q();
        out_q.delete(); osop_q.delete(); oeop_q.delete();
        out_cyc_q.delete(); in_cyc_q.delete(); done_q.delete();
    endtask

    task automatic send(input logic [23:0] d, input logic s, input logic e);
        bit ok;
        ok = 0;
        in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                in_cyc_q.push_back(cyc);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready never high for %h (actual 0, required 1)", d);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; threshold = 8'd128; binarize_en = 1'b1;
        in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: actual %b required 0", out_valid); end
        tests++; if (out_data !== 24'h0) begin fails++; $display("FAIL reset_out_data: actual %h required 000000", out_data); end
        tests++; if ({out_sop, out_eop} !== 2'b00) begin fails++; $display("FAIL reset_sop_eop: actual %b required 00", {out_sop, out_eop}); end
        tests++; if (frame_white_count !== 20'd0) begin fails++; $display("FAIL reset_count: actual %0d required 0", frame_white_count); end
        tests++; if (frame_done !== 1'b0) begin fails++; $display("FAIL reset_frame_done: actual %b required 0", frame_done); end
        reset = 1'b0;
        @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: actual %b required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic_frame();
        logic [23:0] px [4];
        logic [23:0] ex [4];
        px = '{24'hFFFFFF, 24'h000000, 24'h808080, 24'h7F7F7F};
        ex = '{24'hFFFFFF, 24'h000000, 24'hFFFFFF, 24'h000000};
        clear_q();
        threshold = 8'd128; binarize_en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(px[i], i == 0, i == 3);
        drain();
        tests++;
        if (out_q.size() != 4) begin
            fails++; $display("FAIL basic_beats: actual %0d required 4", out_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++; if (out_q[i] !== ex[i]) begin fails++; $display("FAIL basic_data[%0d]: actual %h required %h", i, out_q[i], ex[i]); end
                tests++; if (out_cyc_q[i] - in_cyc_q[i] != 2) begin fails++; $display("FAIL basic_latency[%0d]: actual %0d required 2", i, out_cyc_q[i] - in_cyc_q[i]); end
            end
            tests++; if ({osop_q[0], oeop_q[3], osop_q[1], oeop_q[2]} !== 4'b1100) begin fails++; $display("FAIL basic_framing: actual %b required 1100", {osop_q[0], oeop_q[3], osop_q[1], oeop_q[2]}); end
        end
        tests++;
        if (done_q.size() != 1) begin fails++; $display("FAIL basic_done_pulses: actual %0d required 1", done_q.size()); end
        else if (done_q[0] !== 20'd2) begin fails++; $display("FAIL basic_count: actual %0d required 2", done_q[0]); end
    endtask

    task automatic test_luma();
        clear_q();
        threshold = 8'd128; binarize_en = 1'b0; out_ready = 1'b1;
        send(24'hFF0000, 1'b1, 1'b0);
        send(24'h00FF00, 1'b0, 1'b1);
        drain();
        tests++;
        if (out_q.size() != 2) begin
            fails++; $display("FAIL luma_beats: actual %0d required 2", out_q.size());
        end else begin
            tests++; if (out_q[0] !== 24'h4C4C4C) begin fails++; $display("FAIL luma_red: actual %h required 4c4c4c", out_q[0]); end
            tests++; if (out_q[1] !== 24'h959595) begin fails++; $display("FAIL luma_green: actual %h required 959595", out_q[1]); end
        end
        tests++; if (frame_white_count !== 20'd1) begin fails++; $display("FAIL luma_count: actual %0d required 1", frame_white_count); end
    endtask

    task automatic test_backpressure();
        logic [23:0] held;
        int          bad;
        logic        ir_stall, ov_stall;
        clear_q();
        binarize_en = 1'b0; threshold = 8'd128; out_ready = 1'b1;
        bad = 0; held = '0; ir_stall = 1'b1; ov_stall = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic [23:0] g;
                    g = {3{8'(16 * (i + 1))}};
                    send(g, i == 0, i == 7);
                end
            end
            begin
                for (int i = 0; i < 100 && in_cyc_q.size() < 2; i++) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (i == 0) held = out_data;
                    else if (out_data !== held) bad++;
                    ir_stall = in_ready;
                    ov_stall = out_valid;
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        drain();
        tests++; if (held !== 24'h101010) begin fails++; $display("FAIL bp_held_beat: actual %h required 101010", held); end
        tests++; if (bad != 0) begin fails++; $display("FAIL bp_stable: actual %0d changes required 0", bad); end
        tests++; if ({ov_stall, ir_stall} !== 2'b10) begin fails++; $display("FAIL bp_in_ready: actual valid/ready %b required 10", {ov_stall, ir_stall}); end
        tests++;
        if (out_q.size() != 8) begin
            fails++; $display("FAIL bp_beats: actual %0d required 8", out_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 8; i++) if (out_q[i] !== {3{8'(16 * (i + 1))}}) bad++;
            tests++; if (bad != 0) begin fails++; $display("FAIL bp_order: actual %0d wrong beats required 0", bad); end
        end
    endtask

    task automatic test_random_backpressure();
        logic [23:0] exp_q[$];
        int          exp_cnt[20];
        bit          stop;
        int          bad;
        clear_q();
        binarize_en = 1'b0; threshold = 8'd100; out_ready = 1'b1;
        stop = 0;
        fork
            begin
                for (int f = 0; f < 20; f++) begin
                    exp_cnt[f] = 0;
                    for (int p = 0; p < 50; p++) begin
                        logic [23:0] d;
                        int l;
                        d = 24'($urandom);
                        l = ref_luma(d);
                        exp_q.push_back({3{8'(l)}});
                        if (l >= 100) exp_cnt[f]++;
                        send(d, p == 0, p == 49);
                    end
                end
                stop = 1;
            end
            begin
                while (!stop) begin
                    @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        drain();
        tests++;
        if (out_q.size() != 1000) begin
            fails++; $display("FAIL rand_beats: actual %0d required 1000", out_q.size());
        end else begin
            bad = 0;
            for (int i = 0; i < 1000; i++) begin
                if (out_q[i] !== exp_q[i]) begin
                    if (bad == 0) $display("FAIL rand_data[%0d]: actual %h required %h", i, out_q[i], exp_q[i]);
                    bad++;
                end
            end
            tests++; if (bad != 0) fails++;
        end
        tests++;
        if (done_q.size() != 20) begin
            fails++; $display("FAIL rand_frames: actual %0d required 20", done_q.size());
        end else begin
            for (int f = 0; f < 20; f++) begin
                tests++; if (int'(done_q[f]) != exp_cnt[f]) begin fails++; $display("FAIL rand_count[%0d]: actual %0d required %0d", f, done_q[f], exp_cnt[f]); end
            end
        end
    endtask

    task automatic test_thr_freeze();
        logic [23:0] ex [6];
        ex = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000};
        clear_q();
        binarize_en = 1'b1; threshold = 8'd128; out_ready = 1'b1;
        send(24'h808080, 1'b1, 1'b0);
        send(24'h808080, 1'b0, 1'b0);
        threshold = 8'd255;
        send(24'h808080, 1'b0, 1'b0);
        send(24'h808080, 1'b0, 1'b1);
        send(24'h808080, 1'b1, 1'b0);
        send(24'h808080, 1'b0, 1'b1);
        drain();
        tests++;
        if (out_q.size() != 6) begin
            fails++; $display("FAIL freeze_beats: actual %0d required 6", out_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                tests++; if (out_q[i] !== ex[i]) begin fails++; $display("FAIL freeze_data[%0d]: actual %h required %h", i, out_q[i], ex[i]); end
            end
        end
        tests++;
        if (done_q.size() != 2) begin fails++; $display("FAIL freeze_frames: actual %0d required 2", done_q.size()); end
        else if ({done_q[0], done_q[1]} !== {20'd4, 20'd0}) begin fails++; $display("FAIL freeze_counts: actual %0d/%0d required 4/0", done_q[0], done_q[1]); end
    endtask

    task automatic test_single_beat();
        clear_q();
        binarize_en = 1'b1; threshold = 8'd128; out_ready = 1'b1;
        send(24'hFFFFFF, 1'b1, 1'b1);
        drain();
        tests++;
        if (done_q.size() != 1) begin fails++; $display("FAIL single_done: actual %0d required 1", done_q.size()); end
        else if (done_q[0] !== 20'd1) begin fails++; $display("FAIL single_count: actual %0d required 1", done_q[0]); end
    endtask

    task automatic test_missing_eop();
        clear_q();
        binarize_en = 1'b1; threshold = 8'd128; out_ready = 1'b1;
        send(24'hFFFFFF, 1'b1, 1'b0);
        send(24'hFFFFFF, 1'b0, 1'b0);
        send(24'hFFFFFF, 1'b0, 1'b0);
        drain();
        tests++; if (done_q.size() != 0) begin fails++; $display("FAIL noeop_done: actual %0d required 0", done_q.size()); end
        tests++; if (frame_white_count !== 20'd1) begin fails++; $display("FAIL noeop_hold: actual %0d required 1", frame_white_count); end
        send(24'hFFFFFF, 1'b1, 1'b0);
        send(24'hFFFFFF, 1'b0, 1'b0);
        send(24'h000000, 1'b0, 1'b1);
        drain();
        tests++;
        if (done_q.size() != 1) begin fails++; $display("FAIL restart_done: actual %0d required 1", done_q.size()); end
        else if (done_q[0] !== 20'd2) begin fails++; $display("FAIL restart_count: actual %0d required 2", done_q[0]); end
    endtask

    task automatic test_async_reset();
        binarize_en = 1'b1; threshold = 8'd128; out_ready = 1'b0;
        send(24'h808080, 1'b1, 1'b0);
        send(24'h808080, 1'b0, 1'b0);
        @(negedge clk);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL areset_pre_valid: actual %b required 1", out_valid); end
        reset = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL areset_valid: actual %b required 0", out_valid); end
        tests++; if (frame_white_count !== 20'd0) begin fails++; $display("FAIL areset_count: actual %0d required 0", frame_white_count); end
        @(posedge clk); #1;
        reset = 1'b0;
        clear_q();
        threshold = 8'd255; out_ready = 1'b1;
        send(24'h808080, 1'b0, 1'b0);
        send(24'h7F7F7F, 1'b0, 1'b1);
        drain();
        tests++;
        if (out_q.size() != 2) begin
            fails++; $display("FAIL areset_beats: actual %0d required 2", out_q.size());
        end else begin
            tests++; if ({out_q[0], out_q[1]} !== {24'hFFFFFF, 24'h000000}) begin fails++; $display("FAIL areset_thr: actual %h %h required ffffff 000000", out_q[0], out_q[1]); end
        end
        tests++; if (frame_white_count !== 20'd1) begin fails++; $display("FAIL areset_recount: actual %0d required 1", frame_white_count); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_luma();
        test_backpressure();
        test_random_backpressure();
        test_thr_freeze();
        test_single_beat();
        test_missing_eop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
